seq_divider: RTL

Sequential restoring divider for unsigned WIDTH-bit operands, one quotient bit per clock. It is the inverse companion to the combinational add/sub datapath in the arithmetic library. A single WIDTH+1-bit subtract stage is reused every cycle, with its carry-out serving as the no-borrow flag. It sits beside the adders as the shared divide unit and is driven through a start/done handshake.

---
 rtl/seq_divider_pkg.sv | 9 +
 rtl/seq_divider_sub_stage.sv | 17 +
 rtl/seq_divider.sv | 115 +++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// div_pkg: shared state type and counter sizing for seq_divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DEF_WIDTH = 4;
    localparam int CNT_W = $clog2(DEF_WIDTH + 1);
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/seq_divider_sub_stage.sv
// div_sub_stage: W-bit ripple subtractor a - b as a + ~b + 1; o_cout=1 means no borrow.
module div_sub_stage #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_diff,
    output logic         o_cout
);
    logic [W:0] w_c;
    assign w_c[0] = 1'b1;
    for (genvar g = 0; g < W; g++) begin : g_bit
        assign o_diff[g]  = i_a[g] ^ ~i_b[g] ^ w_c[g];
        assign w_c[g + 1] = (i_a[g] & ~i_b[g]) | (w_c[g] & (i_a[g] ^ ~i_b[g]));
    end
    assign o_cout = w_c[W];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands with sign fix-up and overflow flag.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero,
    output logic             o_v
);
    localparam int CW = cnt_width(WIDTH);
    state_t r_state, w_next;
    logic [WIDTH:0]   r_r, r_d, w_sh, w_diff, w_rn;
    logic [WIDTH-1:0] r_q, w_qn, r_quot, r_rem, w_a, w_b, w_qf, w_rf;
    logic [CW-1:0]    r_cnt;
    logic             r_dbz, w_cout, w_acc, w_zero, w_last;
    assign w_acc  = i_start && r_state != RUN;
    assign w_zero = i_divisor == '0;
    assign w_last = r_state == RUN && r_cnt == CW'(WIDTH - 1);
    // {R,Q} shifted left, then trial subtract of D
    assign w_sh = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
    div_sub_stage #(.W(WIDTH + 1)) u_sub (
        .i_a    (w_sh),
        .i_b    (r_d),
        .o_diff (w_diff),
        .o_cout (w_cout)
    );
    assign w_rn = w_cout ? w_diff : w_sh;
    assign w_qn = {r_q[WIDTH-2:0], w_cout};
    always_comb begin
        w_next = r_state;
        if (r_state == RUN)
            w_next = w_last ? DONE : RUN;
        else
            w_next = i_start ? (w_zero ? DONE : RUN) : IDLE;
    end
`ifdef DIV_SIGNED_EN
    logic r_qneg, r_rneg, r_ov, r_v;
    assign w_a  = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
    assign w_b  = i_divisor[WIDTH-1] ? -i_divisor : i_divisor;
    assign w_qf = r_qneg ? -w_qn : w_qn;
    assign w_rf = r_rneg ? -w_rn[WIDTH-1:0] : w_rn[WIDTH-1:0];
    assign o_v  = r_v;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_ov   <= 1'b0;
            r_v    <= 1'b0;
        end else if (w_acc) begin
            r_qneg <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
            r_rneg <= i_dividend[WIDTH-1];
            r_ov   <= i_dividend == {1'b1, {(WIDTH-1){1'b0}}} && i_divisor == '1;
            if (w_zero)
                r_v <= 1'b0;
        end else if (w_last) begin
            r_v <= r_ov;
        end
    end
`else
    assign w_a  = i_dividend;
    assign w_b  = i_divisor;
    assign w_qf = w_qn;
    assign w_rf = w_rn[WIDTH-1:0];
    assign o_v  = 1'b0;
`endif
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_r     <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_r   <= '0;
                r_q   <= w_a;
                r_d   <= {1'b0, w_b};
                r_cnt <= '0;
                if (w_zero) begin
                    r_quot <= '1;
                    r_rem  <= i_dividend;
                    r_dbz  <= 1'b1;
                end
            end else if (r_state == RUN) begin
                r_r   <= w_rn;
                r_q   <= w_qn;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_quot <= w_qf;
                    r_rem  <= w_rf;
                    r_dbz  <= 1'b0;
                end
            end
        end
    end
    assign o_busy        = r_state == RUN;
    assign o_done        = r_state == DONE;
    assign o_quotient    = r_quot;
    assign o_remainder   = r_rem;
    assign o_div_by_zero = r_dbz;
endmodule
